// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage.
// Issues one read to instruction memory, holds the returned word until the
// decode stage takes it, then fetches the next sequential word. A branch
// redirect from execute wins over every other event.
// Optional feature: define FETCH_STALL_CNT_EN to add the 32-bit stall_cnt
// output (cycles with inst_valid=1 and inst_ready=0, saturating).
//
// Handshakes:
//   imem  : imem_req/imem_addr stay stable until imem_ack=1 is seen at a
//           rising edge; imem_ack is ignored unless imem_req=1.
//   decode: inst_valid/instruction/inst_pc stay stable until inst_ready=1 is
//           seen at a rising edge with inst_valid=1; that edge is the transfer.
module fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        branch_valid,
   input  logic [63:0] branch_target,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] instruction,
   output logic [63:0] inst_pc,
`ifdef FETCH_STALL_CNT_EN
   output logic [31:0] stall_cnt,
`endif
   output logic [1:0]  fsm_state
);

   localparam logic [63:0] RESET_PC_AL = {RESET_PC[63:2], 2'b00};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic        req_d;
   logic        valid_d;
   logic        capture;

   // The request address is the pc register itself, so it is always aligned.
   assign imem_addr = pc_q;
   assign fsm_state = state_q;

   // Next-state, next-pc and next-output decode; branch overrides the rest.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      req_d   = imem_req;
      valid_d = inst_valid;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = REQ;
            pc_d    = RESET_PC_AL;
            req_d   = 1'b1;
            valid_d = 1'b0;
         end
         REQ: begin
            if (imem_ack) begin
               state_d = HOLD;
               req_d   = 1'b0;
               valid_d = 1'b1;
               capture = 1'b1;
            end
         end
         HOLD: begin
            if (inst_ready) begin
               state_d = REQ;
               pc_d    = pc_q + 64'd4;
               req_d   = 1'b1;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
      endcase
      // A redirect drops any returning word and any held word alike.
      if (branch_valid && (state_q != IDLE)) begin
         state_d = REQ;
         pc_d    = {branch_target[63:2], 2'b00};
         req_d   = 1'b1;
         valid_d = 1'b0;
         capture = 1'b0;
      end
   end

   // State, pc and registered outputs; reset abandons any outstanding request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC_AL;
         imem_req    <= 1'b0;
         inst_valid  <= 1'b0;
         instruction <= 32'h0;
         inst_pc     <= 64'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         imem_req   <= req_d;
         inst_valid <= valid_d;
         if (capture) begin
            instruction <= imem_rdata;
            inst_pc     <= pc_q;
         end
      end
   end

`ifdef FETCH_STALL_CNT_EN
   // Count cycles where a word is offered but decode is not taking it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= 32'h0;
      end else if (inst_valid && !inst_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a fetch scoreboard.
// Each entry of exp_q is {pc, word} pushed when the bench returns a word
// from memory, and popped when decode accepts it.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        branch_valid;
  logic [63:0] branch_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [63:0] inst_pc;
  logic [1:0]  fsm_state;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_chk;
  int n_err;
  int exp_stall;
  logic [95:0] exp_q[$];
  longint t0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(64'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .instruction   (instruction),
    .inst_pc       (inst_pc),
`ifdef FETCH_STALL_CNT_EN
    .stall_cnt     (stall_cnt),
`endif
    .fsm_state     (fsm_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {63'h0, imem_req},   64'h0);
    chk({tag, "_addr"},  imem_addr,           64'h0);
    chk({tag, "_valid"}, {63'h0, inst_valid}, 64'h0);
    chk({tag, "_instr"}, {32'h0, instruction}, 64'h0);
    chk({tag, "_ipc"},   inst_pc,             64'h0);
    chk({tag, "_state"}, {62'h0, fsm_state},  64'h0);
  endtask

  // driver: serve one read at exp_addr after 'delay' cycles of no ack
  task automatic fetch_one(input int delay, input logic [63:0] exp_addr, input logic [31:0] data);
    for (int i = 0; i < delay; i++) begin
      chk("wait_req",   {63'h0, imem_req},   64'h1);
      chk("wait_addr",  imem_addr,           exp_addr);
      chk("wait_valid", {63'h0, inst_valid}, 64'h0);
      tick();
    end
    chk("req",  {63'h0, imem_req}, 64'h1);
    chk("addr", imem_addr,         exp_addr);
    imem_ack   = 1'b1;
    imem_rdata = data;
    exp_q.push_back({exp_addr, data});
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("hold_valid", {63'h0, inst_valid}, 64'h1);
    chk("hold_req",   {63'h0, imem_req},   64'h0);
    chk("hold_instr", {32'h0, instruction}, {32'h0, data});
  endtask

  // driver: stall decode for 'stall' cycles, then accept and check next addr
  task automatic consume(input int stall, input logic [63:0] next_addr);
    logic [95:0] e;
    inst_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", {63'h0, inst_valid}, 64'h1);
      chk("stall_req",   {63'h0, imem_req},   64'h0);
      if (exp_q.size() != 0) begin
        chk("stall_instr", {32'h0, instruction}, {32'h0, exp_q[0][31:0]});
        chk("stall_ipc",   inst_pc,              exp_q[0][95:32]);
      end
      exp_stall++;
      tick();
    end
`ifdef FETCH_STALL_CNT_EN
    chk("stall_cnt", {32'h0, stall_cnt}, {32'h0, exp_stall[31:0]});
`endif
    inst_ready = 1'b1;
    chk("take_valid", {63'h0, inst_valid}, 64'h1);
    if (exp_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL sb_empty: observed=word offered expected=no word");
    end else begin
      e = exp_q.pop_front();
      chk("sb_instr", {32'h0, instruction}, {32'h0, e[31:0]});
      chk("sb_ipc",   inst_pc,              e[95:32]);
    end
    tick();
    chk("next_valid", {63'h0, inst_valid}, 64'h0);
    chk("next_req",   {63'h0, imem_req},   64'h1);
    chk("next_addr",  imem_addr,           next_addr);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    exp_stall = 0;
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    branch_valid = 1'b0;
    branch_target = 64'h0;
    inst_ready = 1'b1;

    // reset values, then release into IDLE and step to REQ
    #22;
    chk_reset_outputs("rst");
    tick();
    rst_n = 1'b1;
    chk("idle_state", {62'h0, fsm_state}, 64'h0);
    chk("idle_req",   {63'h0, imem_req},  64'h0);
    tick();
    chk("first_state", {62'h0, fsm_state}, 64'h1);

    // sequential fetch, one word every two cycles
    t0 = $time;
    for (int i = 0; i < 4; i++) begin
      fetch_one(0, 64'(i * 4), $urandom);
      consume(0, 64'(i * 4 + 4));
    end
    chk("throughput_time", 64'($time - t0), 64'd80);

    // slow memory: ack after 3 wait cycles
    fetch_one(3, 64'h10, 32'h7C22_1A14);
    consume(0, 64'h14);

    // decode stalls for 5 cycles
    fetch_one(1, 64'h14, $urandom);
    consume(5, 64'h18);

    // branch coincident with ack: word dropped, refetch at aligned target
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    branch_valid = 1'b1;
    branch_target = 64'h103;
    tick();
    imem_ack = 1'b0;
    branch_valid = 1'b0;
    chk("br_ack_valid", {63'h0, inst_valid}, 64'h0);
    chk("br_ack_req",   {63'h0, imem_req},   64'h1);
    chk("br_ack_addr",  imem_addr,           64'h100);
    tick();
    chk("br_ack_nopulse", {63'h0, inst_valid}, 64'h0);
    fetch_one(0, 64'h100, $urandom);
    consume(0, 64'h104);

    // branch coincident with handshake: word consumed, no refetch
    fetch_one(0, 64'h104, $urandom);
    branch_valid = 1'b1;
    branch_target = 64'h200;
    begin
      logic [95:0] e;
      e = exp_q.pop_front();
      chk("br_hs_instr", {32'h0, instruction}, {32'h0, e[31:0]});
      chk("br_hs_ipc",   inst_pc,              e[95:32]);
    end
    tick();
    branch_valid = 1'b0;
    chk("br_hs_addr",  imem_addr,           64'h200);
    chk("br_hs_valid", {63'h0, inst_valid}, 64'h0);

    // branch while holding an unaccepted word: word discarded
    fetch_one(0, 64'h200, $urandom);
    inst_ready = 1'b0;
    branch_valid = 1'b1;
    branch_target = 64'h300;
    void'(exp_q.pop_front());
    exp_stall++;
    tick();
    branch_valid = 1'b0;
    inst_ready = 1'b1;
    chk("br_hold_addr",  imem_addr,           64'h300);
    chk("br_hold_valid", {63'h0, inst_valid}, 64'h0);
`ifdef FETCH_STALL_CNT_EN
    chk("br_hold_cnt", {32'h0, stall_cnt}, {32'h0, exp_stall[31:0]});
`endif

    // top-of-address-space wrap
    branch_valid = 1'b1;
    branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    branch_valid = 1'b0;
    chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch_one(0, 64'hFFFF_FFFF_FFFF_FFFC, $urandom);
    consume(0, 64'h0);

    // asynchronous reset mid-REQ, checked before any clock edge
    #3;
    rst_n = 1'b0;
    exp_stall = 0;
    #1;
    chk_reset_outputs("async_rst");
`ifdef FETCH_STALL_CNT_EN
    chk("async_rst_cnt", {32'h0, stall_cnt}, 64'h0);
`endif
    tick();
    tick();
    chk_reset_outputs("held_rst");
    // branch and stray ack during IDLE are ignored
    branch_valid = 1'b1;
    branch_target = 64'h500;
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    #3;
    rst_n = 1'b1;
    tick();
    branch_valid = 1'b0;
    imem_ack = 1'b0;
    chk("restart_state", {62'h0, fsm_state}, 64'h1);
    chk("restart_valid", {63'h0, inst_valid}, 64'h0);
    chk("restart_addr",  imem_addr,           64'h0);
    fetch_one(0, 64'h0, $urandom);
    consume(0, 64'h4);

    chk("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL set the first fetch address after reset; bits [1:0] are ignored and treated as 0.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-005 imem_addr  output  64  SHALL be the byte address of the requested word, always 4-aligned.
REQ-006 imem_ack  input  1  SHALL be the memory response strobe, meaningful only while imem_req=1.
REQ-007 imem_rdata  input  32  SHALL be the instruction word, valid when imem_ack=1.
REQ-008 branch_valid  input  1  SHALL be the redirect request from execute.
REQ-009 branch_target  input  64  SHALL be the redirect address; bits [1:0] are forced to 0 internally.
REQ-010 inst_valid  output  1  SHALL indicate that instruction and inst_pc hold a valid fetched word.
REQ-011 inst_ready  input  1  SHALL indicate that the downstream decode/parse stage accepts the word this cycle.
REQ-012 instruction  output  32  SHALL be the fetched word, laid out as opcode [31:26] and fields below.
REQ-013 inst_pc  output  64  SHALL be the address the held instruction was fetched from.

Function
REQ-014 FSM states SHALL be IDLE, REQ and HOLD; all outputs SHALL be registered.
REQ-015 IDLE -> REQ SHALL occur on the first rising edge after rst_n deasserts, with pc=RESET_PC.
REQ-016 In REQ: imem_req=1 and imem_addr=pc; inst_valid=0.
REQ-017 REQ with imem_ack=1 at an edge SHALL transition to HOLD, capturing instruction<=imem_rdata and inst_pc<=pc, with inst_valid=1 from the next cycle.
REQ-018 REQ with imem_ack=0 SHALL remain in REQ, holding imem_req and imem_addr stable.
REQ-019 In HOLD: imem_req=0; instruction and inst_pc SHALL stay stable while inst_ready=0.
REQ-020 HOLD with inst_ready=1 at an edge SHALL complete the handshake: pc<=pc+4 (modulo 2^64), state->REQ, inst_valid->0.
REQ-021 Steady-state throughput SHALL be one instruction per 2 cycles, given 1-cycle ack and constant ready.
REQ-022 branch_valid=1 at an edge, in any non-IDLE state, SHALL set pc<=branch_target & ~3, state->REQ and inst_valid->0; branch SHALL take priority over all other events.
REQ-023 branch_valid and imem_ack at the same edge SHALL discard imem_rdata; the next request SHALL go to the target.
REQ-024 branch_valid and a HOLD handshake at the same edge SHALL treat the held word as consumed and SHALL NOT refetch it.
REQ-025 branch_valid in IDLE SHALL be ignored.
REQ-026 pc=64'hFFFF_FFFF_FFFF_FFFC followed by a handshake SHALL wrap pc to 0.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, instruction=0, inst_pc=0, regardless of clk.
REQ-028 Reset asserted mid-REQ SHALL abandon the outstanding request; an imem_ack arriving after reset release while in IDLE SHALL be ignored.

Configuration
REQ-029 Macro FETCH_STALL_CNT_EN defined SHALL add output port stall_cnt (32 bits). It SHALL increment each cycle in which inst_valid=1 and inst_ready=0, saturate at 32'hFFFF_FFFF, and reset to 0 under rst_n.
REQ-030 Macro FETCH_STALL_CNT_EN undefined SHALL remove the stall_cnt port and counter; all other behaviour SHALL be identical.

Verification
REQ-031 Release reset with RESET_PC=0, ack=1 one cycle after each req, inst_ready=1 -> imem_addr sequence 0,4,8,C; inst_pc matches each address; one word every 2 cycles.
REQ-032 Ack delayed 3 cycles, imem_rdata=32'h7C221A14 -> imem_req/addr stable for 3 cycles; instruction=32'h7C221A14 and inst_valid=1 on the following cycle.
REQ-033 HOLD with inst_ready=0 for 5 cycles -> outputs stable; stall_cnt=5 with FETCH_STALL_CNT_EN; then ready=1 -> pc advances by 4.
REQ-034 branch_valid with target 64'h103 coincident with imem_ack -> data discarded; next imem_addr=64'h100; no inst_valid pulse for the discarded word.
REQ-035 Start at pc=64'hFFFF_FFFF_FFFF_FFFC, complete a handshake -> next imem_addr=0.
REQ-036 rst_n pulsed low mid-REQ, asynchronously to clk -> outputs reach reset values without a clock edge; fetch restarts at RESET_PC.
